pll_lock_supervisor: RTL and testbench

- Sits directly downstream of the PLL wrapper and runs on the PLL output clock (126 MHz default).
- Synchronises and qualifies the raw PLL lock signal, then releases a parametrised set of domain resets in a staggered sequence.
- Generates NUM_CH runtime-programmable clock-enable ticks (e.g. 1 Hz RTC tick, display scan tick) and counts lock-loss events.
- On lock loss it re-asserts all resets and restarts the qualification sequence.

---
 rtl/pll_lock_supervisor.sv | 240 ++++++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor.
// Runs on the PLL output clock. It synchronises and qualifies the raw lock,
// releases the domain resets one after another, generates programmable
// clock-enable ticks while running, and counts lock-loss events. Any loss of
// lock during release or run drops every domain back into reset and restarts
// qualification.
module pll_lock_supervisor #(
    parameter int unsigned             LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned             NUM_RST            = 3,
    parameter int unsigned             RST_STAGGER        = 16,
    parameter int unsigned             NUM_CH             = 2,
    parameter int unsigned             DIV_W              = 32,
    parameter int unsigned             LOSS_W             = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT           = {NUM_CH{32'd126000000}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_lock,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    div_load,
    output logic [NUM_RST-1:0]      dom_rst_n,
    output logic                    ready,
    output logic [NUM_CH-1:0]       tick,
    output logic [LOSS_W-1:0]       loss_cnt,
    output logic [2:0]              state_o
);

    // ------------------------------------------------------------------
    // State encoding (kept as plain constants so debug tools that decode
    // state_o numerically stay compatible).
    // ------------------------------------------------------------------
    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_QUALIFY   = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_LOST      = 3'd4;

    // The qualification counter only ever holds 0..LOCK_STABLE_CYCLES-1:
    // the cycle that would reach LOCK_STABLE_CYCLES moves straight on to
    // RELEASE instead of storing the final value.
    localparam int unsigned QW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    // The stagger counter likewise holds 0..RST_STAGGER-1.
    localparam int unsigned SW = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;

    localparam logic [QW-1:0]     QUAL_LAST = QW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SW-1:0]     STG_LAST  = SW'(RST_STAGGER - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = {LOSS_W{1'b1}};

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                    sync_q;
    logic                    lock_s;

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [QW-1:0]           qual_cnt;
    logic [QW-1:0]           qual_nxt;
    logic [SW-1:0]           stg_cnt;
    logic [SW-1:0]           stg_nxt;
    logic [NUM_RST-1:0]      dom_nxt;
    logic                    ready_nxt;

    // Lock dropped while domains were (partly) out of reset.
    logic                    loss_evt;

    logic [NUM_CH*DIV_W-1:0] div_q;
    logic [DIV_W-1:0]        div_ch [NUM_CH];
    logic [DIV_W-1:0]        cnt    [NUM_CH];

    assign state_o  = state;
    assign loss_evt = !lock_s && (state == S_RELEASE || state == S_RUN);

    // Two-flop synchroniser bringing the asynchronous PLL lock into clk.
    // NOTE: every clocked register uses non-blocking assignments so all flops
    // sample the pre-edge values, just like the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_lock;
            lock_s <= sync_q;
        end
    end

    // Sequencer decisions: qualification, staggered release, loss handling.
    // NOTE: every output of this block gets a hold value up front so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        qual_nxt  = qual_cnt;
        stg_nxt   = stg_cnt;
        dom_nxt   = dom_rst_n;
        ready_nxt = ready;

        case (state)
            // WAIT_LOCK and QUALIFY share one rule: each synchronised-high
            // cycle extends the streak; the cycle that completes it releases
            // domain 0 directly. A low cycle abandons the streak without
            // counting as a loss, because nothing had been released yet.
            S_WAIT_LOCK, S_QUALIFY: begin
                if (lock_s) begin
                    if (qual_cnt == QUAL_LAST) begin
                        state_nxt = S_RELEASE;
                        qual_nxt  = '0;
                        stg_nxt   = '0;
                        dom_nxt   = NUM_RST'(1);
                    end else begin
                        state_nxt = S_QUALIFY;
                        qual_nxt  = qual_cnt + QW'(1);
                    end
                end else begin
                    state_nxt = S_WAIT_LOCK;
                    qual_nxt  = '0;
                end
            end

            // Domains are released in index order, so dom_rst_n is always a
            // thermometer code: shifting in a one releases the next domain.
            // Once the top domain is out of reset, the following cycle
            // enters RUN.
            S_RELEASE: begin
                if (!lock_s) begin
                    state_nxt = S_LOST;
                    stg_nxt   = '0;
                    dom_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (dom_rst_n[NUM_RST-1]) begin
                    state_nxt = S_RUN;
                    stg_nxt   = '0;
                    ready_nxt = 1'b1;
                end else if (stg_cnt == STG_LAST) begin
                    stg_nxt = '0;
                    dom_nxt = (dom_rst_n << 1) | NUM_RST'(1);
                end else begin
                    stg_nxt = stg_cnt + SW'(1);
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_LOST;
                    dom_nxt   = '0;
                    ready_nxt = 1'b0;
                end
            end

            // LOST lasts exactly one cycle so the loss is visible on state_o
            // before qualification starts over.
            S_LOST: begin
                state_nxt = S_WAIT_LOCK;
                qual_nxt  = '0;
            end

            default: begin
                state_nxt = S_WAIT_LOCK;
                qual_nxt  = '0;
                stg_nxt   = '0;
                dom_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer registers, including the registered reset and ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_WAIT_LOCK;
            qual_cnt  <= '0;
            stg_cnt   <= '0;
            dom_rst_n <= '0;
            ready     <= 1'b0;
        end else begin
            state     <= state_nxt;
            qual_cnt  <= qual_nxt;
            stg_cnt   <= stg_nxt;
            dom_rst_n <= dom_nxt;
            ready     <= ready_nxt;
        end
    end

    // Saturating lock-loss counter; qualification glitches are not losses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (loss_evt && loss_cnt != LOSS_MAX) begin
            loss_cnt <= loss_cnt + LOSS_W'(1);
        end
    end

    // Divisor bank: reloaded from div_cfg on a load strobe in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_INIT;
        end else if (div_load) begin
            div_q <= div_cfg;
        end
    end

    // Split the packed divisor bank into per-channel values.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_ch[i] = div_q[i*DIV_W +: DIV_W];
        end
    end

    // Tick channels. The counters only advance on cycles that were already in
    // RUN, so the RUN entry cycle is count 0 and the first tick of divisor D
    // appears D cycles after ready rises. A load, leaving RUN, or a lock loss
    // all restart the count and suppress the tick for that edge.
    // NOTE: the per-channel counters are individual flops, not a RAM, so they
    // are cleared by the asynchronous reset like every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_load || state != S_RUN || loss_evt) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                end else if (div_ch[i] == '0) begin
                    // Divisor 0 disables the channel.
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                end else if (cnt[i] == div_ch[i] - DIV_W'(1)) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b1;
                end else begin
                    cnt[i]  <= cnt[i] + DIV_W'(1);
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor.
// A behavioural model (lock streak, elapsed-time since release, age since the
// tick reference point) predicts every output each cycle; directed scenarios
// add hand-computed timing expectations, followed by randomised lock/reload
// traffic, saturation of the loss counter and an asynchronous reset.
module tb_pll_lock_supervisor;

    localparam int LSC    = 8;
    localparam int NRST   = 3;
    localparam int STG    = 4;
    localparam int NCH    = 2;
    localparam int DW     = 8;
    localparam int LW     = 2;
    localparam int RUN_AT = (NRST - 1) * STG + 1;   // cycles from first release to RUN
    localparam int LMAX   = (1 << LW) - 1;

    logic                clk;
    logic                rst_n;
    logic                pll_lock;
    logic [NCH*DW-1:0]   div_cfg;
    logic                div_load;
    logic [NRST-1:0]     dom_rst_n;
    logic                ready;
    logic [NCH-1:0]      tick;
    logic [LW-1:0]       loss_cnt;
    logic [2:0]          state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES (LSC),
        .NUM_RST            (NRST),
        .RST_STAGGER        (STG),
        .NUM_CH             (NCH),
        .DIV_W              (DW),
        .LOSS_W             (LW),
        .DIV_INIT           (16'h0005)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .div_cfg   (div_cfg),
        .div_load  (div_load),
        .dom_rst_n (dom_rst_n),
        .ready     (ready),
        .tick      (tick),
        .loss_cnt  (loss_cnt),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit m_q0, m_q1;        // two-cycle delay of pll_lock
    int m_streak;          // consecutive synchronised-high cycles while unqualified
    bit m_active;          // domains being released or running
    int m_t;               // edges since domain 0 was released
    bit m_lost;            // the one-cycle LOST interval
    int m_loss;
    int m_age;             // edges since RUN entry or last divisor load
    int m_div [NCH];
    int e_dom, e_ready, e_tick, e_state;

    task automatic model_outputs();
        int nb;
        if (m_active) begin
            nb = m_t / STG + 1;
            if (nb > NRST) nb = NRST;
            e_dom = (1 << nb) - 1;
        end else begin
            e_dom = 0;
        end
        e_ready = (m_active && m_t >= RUN_AT) ? 1 : 0;
        if (m_lost)            e_state = 4;
        else if (e_ready == 1) e_state = 3;
        else if (m_active)     e_state = 2;
        else if (m_streak > 0) e_state = 1;
        else                   e_state = 0;
    endtask

    task automatic model_reset();
        m_q0 = 0; m_q1 = 0;
        m_streak = 0; m_active = 0; m_t = 0; m_lost = 0;
        m_loss = 0; m_age = 0;
        m_div[0] = 5; m_div[1] = 0;
        e_tick = 0;
        model_outputs();
    endtask

    task automatic model_step();
        bit ls, pre_run, post_run, load;
        ls   = m_q1;
        m_q1 = m_q0;
        m_q0 = pll_lock;
        load = div_load;
        pre_run = m_active && m_t >= RUN_AT;

        if (m_lost) begin
            m_lost   = 0;
            m_streak = 0;
        end else if (m_active) begin
            if (!ls) begin
                m_active = 0;
                m_lost   = 1;
                if (m_loss < LMAX) m_loss++;
            end else begin
                m_t++;
            end
        end else if (ls) begin
            m_streak++;
            if (m_streak == LSC) begin
                m_active = 1;
                m_t      = 0;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end

        post_run = m_active && m_t >= RUN_AT;
        if (load || !pre_run || !post_run) m_age = 0;
        else                               m_age++;

        e_tick = 0;
        for (int i = 0; i < NCH; i++) begin
            if (pre_run && post_run && !load && m_div[i] != 0 && (m_age % m_div[i]) == 0)
                e_tick |= (1 << i);
        end
        if (load) begin
            for (int i = 0; i < NCH; i++) m_div[i] = int'(div_cfg[i*DW +: DW]);
        end
        model_outputs();
    endtask

    // Compare process: model advances on every rising edge, outputs are
    // checked on the following falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            @(negedge clk);
            check("dom_rst_n", 32'(dom_rst_n), 32'(e_dom));
            check("ready",     32'(ready),     32'(e_ready));
            check("tick",      32'(tick),      32'(e_tick));
            check("loss_cnt",  32'(loss_cnt),  32'(m_loss));
            check("state_o",   32'(state_o),   32'(e_state));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        check("wait_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int hold;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        div_load = 1'b0;
        div_cfg  = '0;
        #1;
        check("rst_dom",   32'(dom_rst_n), 32'd0);
        check("rst_ready", 32'(ready),     32'd0);
        check("rst_tick",  32'(tick),      32'd0);
        check("rst_loss",  32'(loss_cnt),  32'd0);
        check("rst_state", 32'(state_o),   32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Clean lock-up.
        pll_lock = 1'b1;
        cyc(9);  check("clean_qual_dom",   32'(dom_rst_n), 32'b000);
                 check("clean_qual_state", 32'(state_o),   32'd1);
        cyc(1);  check("clean_rel0",       32'(dom_rst_n), 32'b001);
                 check("clean_rel_state",  32'(state_o),   32'd2);
        cyc(3);  check("clean_hold0",      32'(dom_rst_n), 32'b001);
        cyc(1);  check("clean_rel1",       32'(dom_rst_n), 32'b011);
        cyc(4);  check("clean_rel2",       32'(dom_rst_n), 32'b111);
                 check("clean_not_ready",  32'(ready),     32'd0);
        cyc(1);  check("clean_ready",      32'(ready),     32'd1);
                 check("clean_run_state",  32'(state_o),   32'd3);
        cyc(4);  check("clean_no_tick",    32'(tick),      32'b00);
        cyc(1);  check("clean_tick1",      32'(tick),      32'b01);
        cyc(4);  check("clean_gap",        32'(tick),      32'b00);
        cyc(1);  check("clean_tick2",      32'(tick),      32'b01);

        // Reprogram in RUN: ch0=2, ch1=3.
        div_cfg  = {8'd3, 8'd2};
        div_load = 1'b1;
        cyc(1);  check("load_no_tick",     32'(tick), 32'b00);
        div_load = 1'b0;
        cyc(1);  check("load_p1",          32'(tick), 32'b00);
        cyc(1);  check("load_p2",          32'(tick), 32'b01);
        cyc(1);  check("load_p3",          32'(tick), 32'b10);
        cyc(1);  check("load_p4",          32'(tick), 32'b01);
        cyc(2);  check("load_p6",          32'(tick), 32'b11);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        cyc(2);  check("loss_still_run",   32'(state_o),   32'd3);
        cyc(1);  check("loss_dom",         32'(dom_rst_n), 32'b000);
                 check("loss_ready",       32'(ready),     32'd0);
                 check("loss_tick",        32'(tick),      32'b00);
                 check("loss_cnt1",        32'(loss_cnt),  32'd1);
                 check("loss_state",       32'(state_o),   32'd4);
        cyc(1);  check("loss_to_wait",     32'(state_o),   32'd0);

        // Glitchy lock: 5 high, 1 low, then high.
        pll_lock = 1'b1;
        cyc(5);
        pll_lock = 1'b0;
        cyc(1);
        pll_lock = 1'b1;
        cyc(9);  check("glitch_not_yet",   32'(dom_rst_n), 32'b000);
        cyc(1);  check("glitch_rel0",      32'(dom_rst_n), 32'b001);
                 check("glitch_no_loss",   32'(loss_cnt),  32'd1);

        // Loss mid-RELEASE after 011.
        cyc(4);  check("mid_rel1",         32'(dom_rst_n), 32'b011);
        pll_lock = 1'b0;
        cyc(3);  check("mid_drop",         32'(dom_rst_n), 32'b000);
                 check("mid_loss_cnt",     32'(loss_cnt),  32'd2);
        cyc(1);
        pll_lock = 1'b1;
        cyc(9);  check("relock_wait",      32'(dom_rst_n), 32'b000);
        cyc(1);  check("relock_bit0",      32'(dom_rst_n), 32'b001);
        cyc(4);  check("relock_bit1",      32'(dom_rst_n), 32'b011);
        cyc(4);  check("relock_bit2",      32'(dom_rst_n), 32'b111);
        cyc(1);  check("relock_ready",     32'(ready),     32'd1);

        // Randomised lock activity and divisor reloads.
        for (int it = 0; it < 120; it++) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            hold     = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    div_cfg  = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
                    div_load = 1'b1;
                end
                cyc(1);
                div_load = 1'b0;
            end
        end

        // Force three more losses so the 2-bit counter must saturate.
        pll_lock = 1'b0;
        cyc(4);
        for (int k = 0; k < 3; k++) begin
            pll_lock = 1'b1;
            wait_ready(60);
            pll_lock = 1'b0;
            cyc(4);
        end
        check("loss_saturated", 32'(loss_cnt), 32'd3);

        // Asynchronous reset mid-RUN.
        pll_lock = 1'b1;
        wait_ready(60);
        cyc(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dom",   32'(dom_rst_n), 32'd0);
        check("arst_ready", 32'(ready),     32'd0);
        check("arst_tick",  32'(tick),      32'd0);
        check("arst_loss",  32'(loss_cnt),  32'd0);
        check("arst_state", 32'(state_o),   32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        wait_ready(60);
        cyc(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
